// File: rtl/mips_ctrl_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the MIPS32 main decoder.
package mips_ctrl_pkg;

   localparam int OP_W    = 6;
   localparam int ALUOP_W = 2;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
   localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [ALUOP_W-1:0] ALUOP_OR    = 2'b11;

   typedef struct packed {
      logic               regdst;
      logic               alusrc;
      logic               memtoreg;
      logic               regwrite;
      logic               regwrite2;
      logic               memread;
      logic               memwrite;
      logic               branch;
      logic               branchn;
      logic               lui;
      logic               jump;
      logic               jal;
      logic [ALUOP_W-1:0] aluop;
      logic               illegal_op;
   } ctrl_t;

endpackage

// File: rtl/main_control_decode.sv
// Combinational opcode -> control bundle. Optional addi decode via MAIN_CTRL_ADDI_EN.
module main_control_decode
   import mips_ctrl_pkg::*;
(
   input  logic [OP_W-1:0] op,
   output ctrl_t           ctrl
);

   always_comb begin
      ctrl = '0;
      case (op)
         OP_RTYPE: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.aluop    = ALUOP_RTYPE;
         end
         OP_LW: begin
            ctrl.alusrc   = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.memread  = 1'b1;
            ctrl.aluop    = ALUOP_ADD;
         end
         OP_SW: begin
            ctrl.alusrc   = 1'b1;
            ctrl.memwrite = 1'b1;
            ctrl.aluop    = ALUOP_ADD;
         end
         OP_BEQ: begin
            ctrl.branch = 1'b1;
            ctrl.aluop  = ALUOP_SUB;
         end
         OP_BNE: begin
            ctrl.branchn = 1'b1;
            ctrl.aluop   = ALUOP_SUB;
         end
         OP_ORI: begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.aluop    = ALUOP_OR;
         end
         OP_J: begin
            ctrl.jump  = 1'b1;
            ctrl.aluop = ALUOP_ADD;
         end
         // Link write goes through the dedicated $31 port, not the normal one.
         OP_JAL: begin
            ctrl.jump      = 1'b1;
            ctrl.jal       = 1'b1;
            ctrl.regwrite2 = 1'b1;
            ctrl.aluop     = ALUOP_ADD;
         end
         OP_LUI: begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.lui      = 1'b1;
            ctrl.aluop    = ALUOP_ADD;
         end
`ifdef MAIN_CTRL_ADDI_EN
         OP_ADDI: begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.aluop    = ALUOP_ADD;
         end
`endif
         default: ctrl.illegal_op = 1'b1;
      endcase
   end

endmodule

// File: rtl/main_control_unit.sv
// Registered MIPS32 main decoder: controls appear one cycle after op.
// Optional addi support is enabled by defining MAIN_CTRL_ADDI_EN.
module main_control_unit
   import mips_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [OP_W-1:0]     op,
   output logic                regdst,
   output logic                alusrc,
   output logic                memtoreg,
   output logic                regwrite,
   output logic                regwrite2,
   output logic                memread,
   output logic                memwrite,
   output logic                branch,
   output logic                branchn,
   output logic                lui,
   output logic                jump,
   output logic                jal,
   output logic [ALUOP_W-1:0]  aluop,
   output logic                illegal_op
);

   ctrl_t ctrl_d, ctrl_q;

   main_control_decode u_decode (
      .op   (op),
      .ctrl (ctrl_d)
   );

   always_ff @(posedge clk) begin
      if (rst) ctrl_q <= '0;
      else     ctrl_q <= ctrl_d;
   end

   assign regdst     = ctrl_q.regdst;
   assign alusrc     = ctrl_q.alusrc;
   assign memtoreg   = ctrl_q.memtoreg;
   assign regwrite   = ctrl_q.regwrite;
   assign regwrite2  = ctrl_q.regwrite2;
   assign memread    = ctrl_q.memread;
   assign memwrite   = ctrl_q.memwrite;
   assign branch     = ctrl_q.branch;
   assign branchn    = ctrl_q.branchn;
   assign lui        = ctrl_q.lui;
   assign jump       = ctrl_q.jump;
   assign jal        = ctrl_q.jal;
   assign aluop      = ctrl_q.aluop;
   assign illegal_op = ctrl_q.illegal_op;

endmodule

// File: tb/tb_main_control_unit.sv
// Scoreboard bench for main_control_unit: stimulus pushes expected bundles, monitor pops/compares.
module tb_main_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic regdst, alusrc, memtoreg, regwrite, regwrite2, memread, memwrite;
   logic branch, branchn, lui, jump, jal, illegal_op;
   logic [1:0] aluop;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [14:0] exp;
      string       name;
   } item_t;
   item_t sb[$];

   always #5 clk = ~clk;

   main_control_unit dut (
      .clk(clk), .rst(rst), .op(op),
      .regdst(regdst), .alusrc(alusrc), .memtoreg(memtoreg), .regwrite(regwrite),
      .regwrite2(regwrite2), .memread(memread), .memwrite(memwrite),
      .branch(branch), .branchn(branchn), .lui(lui), .jump(jump), .jal(jal),
      .aluop(aluop), .illegal_op(illegal_op)
   );

   // Bit order: regdst alusrc memtoreg regwrite regwrite2 memread memwrite
   //            branch branchn lui jump jal aluop[1:0] illegal_op
   function automatic logic [14:0] exp_of(input logic [5:0] o);
      case (o)
         6'b000000: return 15'b1_0_0_1_0_0_0_0_0_0_0_0_10_0;
         6'b100011: return 15'b0_1_1_1_0_1_0_0_0_0_0_0_00_0;
         6'b101011: return 15'b0_1_0_0_0_0_1_0_0_0_0_0_00_0;
         6'b000100: return 15'b0_0_0_0_0_0_0_1_0_0_0_0_01_0;
         6'b000101: return 15'b0_0_0_0_0_0_0_0_1_0_0_0_01_0;
         6'b001101: return 15'b0_1_0_1_0_0_0_0_0_0_0_0_11_0;
         6'b000010: return 15'b0_0_0_0_0_0_0_0_0_0_1_0_00_0;
         6'b000011: return 15'b0_0_0_0_1_0_0_0_0_0_1_1_00_0;
         6'b001111: return 15'b0_1_0_1_0_0_0_0_0_1_0_0_00_0;
`ifdef MAIN_CTRL_ADDI_EN
         6'b001000: return 15'b0_1_0_1_0_0_0_0_0_0_0_0_00_0;
`endif
         default:   return 15'b0_0_0_0_0_0_0_0_0_0_0_0_00_1;
      endcase
   endfunction

   task automatic step(input logic r, input logic [5:0] o, input string nm);
      item_t it;
      rst = r;
      op  = o;
      it.exp  = r ? 15'd0 : exp_of(o);
      it.name = nm;
      sb.push_back(it);
      @(negedge clk);
   endtask

   // Monitor: one registered result per rising edge.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         item_t it;
         logic [14:0] act;
         it = sb.pop_front();
         act = {regdst, alusrc, memtoreg, regwrite, regwrite2, memread, memwrite,
                branch, branchn, lui, jump, jal, aluop, illegal_op};
         checks++;
         if (act !== it.exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
         end
         checks++;
         if ((memread && memwrite) || (branch && branchn) || (regwrite && regwrite2)) begin
            failures++;
            $display("FAIL invariant %s: got %b with conflicting pair, required exclusive", it.name, act);
         end
      end
   end

   logic [5:0] sweep [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                             6'b001101, 6'b000010, 6'b000011, 6'b001111};

   initial begin
      // Reset dominates op.
      step(1'b1, 6'b100011, "reset0");
      step(1'b1, 6'b100011, "reset1");
      step(1'b0, 6'b100011, "lw_after_reset");
      foreach (sweep[i]) step(1'b0, sweep[i], $sformatf("sweep_%06b", sweep[i]));
      step(1'b0, 6'b000011, "jal");
      step(1'b0, 6'b111111, "illegal_3f");
      step(1'b0, 6'b001000, "addi");
      // Mid-stream reset pulse with op changing every cycle.
      step(1'b0, 6'b000000, "mid_r");
      step(1'b0, 6'b101011, "mid_sw");
      step(1'b1, 6'b000100, "mid_reset");
      step(1'b0, 6'b000101, "mid_bne");
      step(1'b0, 6'b001111, "mid_lui");
      for (int i = 0; i < 64; i++) step(1'b0, 6'(i), $sformatf("exh_%06b", 6'(i)));
      for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d entries left, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
